// File: rtl/req_level_sequencer.sv
// Round-robin sequencer: turns sticky request levels into one engine operation at a time,
// then pulses a one-hot clear back to the serviced source. Optional WAIT timeout: REQ_SEQ_TIMEOUT_EN.
module req_level_sequencer #(
    parameter int NUM_REQ = 4,
`ifdef REQ_SEQ_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 255,
`endif
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_level,
    output logic [NUM_REQ-1:0] req_clear,
    output logic               op_start,
    output logic [SEL_W-1:0]   op_sel,
    input  logic               op_done,
`ifdef REQ_SEQ_TIMEOUT_EN
    output logic               op_timeout,
`endif
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]   op_sel_q, op_sel_d;
    logic               op_start_q, op_start_d;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] req_clear_q, req_clear_d;

    logic [SEL_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] req_rot;
    logic [SEL_W-1:0]   grant_idx;

`ifdef REQ_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            op_timeout_q, op_timeout_d;
`endif

    // Slot gi of req_rot is the request gi positions above rr_ptr, wrapping modulo NUM_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            logic [SEL_W:0] sum;
            assign sum = {1'b0, rr_ptr_q} + (SEL_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (SEL_W+1)'(NUM_REQ)) ?
                                  SEL_W'(sum - (SEL_W+1)'(NUM_REQ)) : sum[SEL_W-1:0];
            assign req_rot[gi]     = req_level[cand_idx[gi]];
            assign req_clear_d[gi] = (state_d == CLEAR) && (op_sel_d == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        grant_idx = rr_ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                grant_idx = cand_idx[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        op_sel_d = op_sel_q;
        case (state_q)
            IDLE: begin
                if (|req_level) begin
                    op_sel_d = grant_idx;
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (op_done) begin
                    state_d = CLEAR;
                end
`ifdef REQ_SEQ_TIMEOUT_EN
                else if (op_timeout_q) begin
                    state_d = CLEAR;
                end
`endif
            end
            CLEAR: begin
                rr_ptr_d = (op_sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : op_sel_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        op_start_d = (state_d == ISSUE);
        busy_d     = (state_d != IDLE);
    end

`ifdef REQ_SEQ_TIMEOUT_EN
    // op_timeout is raised for the final permitted WAIT cycle, which then exits to CLEAR.
    always_comb begin
        wait_cnt_d   = (state_q == WAIT) ? wait_cnt_q + 1'b1 : '0;
        op_timeout_d = (state_d == WAIT) && (wait_cnt_d == TO_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt_q   <= '0;
            op_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            op_timeout_q <= op_timeout_d;
        end
    end

    assign op_timeout = op_timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_sel_q    <= '0;
            op_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            req_clear_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_sel_q    <= op_sel_d;
            op_start_q  <= op_start_d;
            busy_q      <= busy_d;
            req_clear_q <= req_clear_d;
        end
    end

    assign op_start  = op_start_q;
    assign op_sel    = op_sel_q;
    assign busy      = busy_q;
    assign req_clear = req_clear_q;

endmodule
